mac_acumulador: RTL

//  Datapath responder to the ControlMux-style sequencer: consumes sel_const/sel_fun/sel_acum/Band_Listo

---
 rtl/mac_acumulador_if.sv | 31 +++
 rtl/mac_acumulador.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/mac_acumulador_if.sv
// Sequencer/datapath bus for mac_acumulador: control steps, coefficient writes, samples and frame result.
interface mac_acumulador_if #(
  parameter int W = 16
);
  logic [2:0]          sel_const;
  logic [1:0]          sel_fun;
  logic                sel_acum;
  logic                Band_Listo;
  logic                coef_we;
  logic [2:0]          coef_addr;
  logic signed [W-1:0] coef_data;
  logic signed [W-1:0] fun0;
  logic signed [W-1:0] fun1;
  logic signed [W-1:0] fun2;
  logic signed [W-1:0] resultado;
  logic                res_valido;
  logic                sat;
  logic                err_seq;

  modport master (
    output sel_const, sel_fun, sel_acum, Band_Listo,
    output coef_we, coef_addr, coef_data, fun0, fun1, fun2,
    input  resultado, res_valido, sat, err_seq
  );

  modport slave (
    input  sel_const, sel_fun, sel_acum, Band_Listo,
    input  coef_we, coef_addr, coef_data, fun0, fun1, fun2,
    output resultado, res_valido, sat, err_seq
  );
endinterface

// File: rtl/mac_acumulador.sv
// Frame MAC responder: coef*sample per step, W+3-bit accumulation, saturated result on Band_Listo,
// plus sequencer protocol checking. Define REDONDEO_EN for round-half-up products (default: truncate).
module mac_acumulador #(
  parameter int W      = 16,
  parameter int FRAC   = 8,
  parameter int NCONST = 6
) (
  input  logic             clk,
  input  logic             reset_n,
  mac_acumulador_if.slave  bus
);

  localparam int AW = W + 3;
  localparam int PW = 2*W + 1;

  localparam logic [0:0] ESPERA = 1'b0;
  localparam logic [0:0] ACUM   = 1'b1;

  localparam logic signed [PW-1:0] PMAX = {{(W+2){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [PW-1:0] PMIN = {{(W+2){1'b1}}, {(W-1){1'b0}}};
  localparam logic signed [AW-1:0] RMAX = {4'b0000, {(W-1){1'b1}}};
  localparam logic signed [AW-1:0] RMIN = {4'b1111, {(W-1){1'b0}}};

  logic [0:0]          state, nxt_state;
  logic signed [W-1:0] coef [NCONST];
  logic signed [AW-1:0] acc, nxt_acc;
  logic [3:0]          exp_idx, nxt_exp;
  logic                err_frm, nxt_err;
  logic                sat_frm, nxt_sat;

  logic                idx_bad;
  logic signed [W-1:0] coef_rd;
  logic signed [W-1:0] fun_sel;
  logic signed [2*W-1:0] prod;
  logic signed [PW-1:0] prod_r;
  logic signed [PW-1:0] shifted;
  logic                step_ovf;
  logic signed [AW-1:0] p;
  logic signed [AW-1:0] sum;
  logic                clamp_hi, clamp_lo;
  logic signed [W-1:0] res_clamped;

  logic signed [W-1:0] resultado_q;
  logic                res_valido_q, sat_q, err_q;

  assign idx_bad = ({1'b0, bus.sel_const} >= 4'(NCONST));
  assign coef_rd = idx_bad ? coef[0] : coef[bus.sel_const];

  always_comb begin
    fun_sel = '0;
    case (bus.sel_fun)
      2'd0:    fun_sel = bus.fun0;
      2'd1:    fun_sel = bus.fun1;
      2'd2:    fun_sel = bus.fun2;
      default: fun_sel = '0;
    endcase
  end

  assign prod = coef_rd * fun_sel;

`ifdef REDONDEO_EN
  assign prod_r = {prod[2*W-1], prod} + PW'(1 << (FRAC-1));
`else
  assign prod_r = {prod[2*W-1], prod};
`endif

  // Arithmetic shift gives floor division, i.e. truncation toward -inf.
  assign shifted  = prod_r >>> FRAC;
  assign step_ovf = (shifted > PMAX) || (shifted < PMIN);

  // Products are clipped to W bits so six of them can never wrap the W+3 accumulator.
  always_comb begin
    p = shifted[AW-1:0];
    if (step_ovf) p = shifted[PW-1] ? PMIN[AW-1:0] : PMAX[AW-1:0];
  end

  assign sum = acc + p;

  always_comb begin
    nxt_state = state;
    nxt_acc   = acc;
    nxt_exp   = exp_idx;
    nxt_err   = err_frm;
    nxt_sat   = sat_frm;
    if (!bus.sel_acum) begin
      // Frame start; a start while already accumulating is a restart and is flagged.
      nxt_acc   = p;
      nxt_exp   = {1'b0, bus.sel_const} + 4'd1;
      nxt_err   = idx_bad | (state == ACUM);
      nxt_sat   = step_ovf;
      nxt_state = bus.Band_Listo ? ESPERA : ACUM;
    end else if (state == ESPERA) begin
      nxt_err = 1'b1;
    end else begin
      nxt_acc = sum;
      nxt_exp = exp_idx + 4'd1;
      nxt_err = err_frm | idx_bad | ({1'b0, bus.sel_const} != exp_idx);
      nxt_sat = sat_frm | step_ovf;
      if (bus.Band_Listo) nxt_state = ESPERA;
    end
  end

  assign clamp_hi = (nxt_acc > RMAX);
  assign clamp_lo = (nxt_acc < RMIN);

  always_comb begin
    res_clamped = nxt_acc[W-1:0];
    if (clamp_hi)      res_clamped = RMAX[W-1:0];
    else if (clamp_lo) res_clamped = RMIN[W-1:0];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= ESPERA;
      acc          <= '0;
      exp_idx      <= '0;
      err_frm      <= 1'b0;
      sat_frm      <= 1'b0;
      resultado_q  <= '0;
      res_valido_q <= 1'b0;
      sat_q        <= 1'b0;
      err_q        <= 1'b0;
      for (int i = 0; i < NCONST; i++) coef[i] <= '0;
    end else begin
      state        <= nxt_state;
      acc          <= nxt_acc;
      exp_idx      <= nxt_exp;
      err_frm      <= nxt_err;
      sat_frm      <= nxt_sat;
      res_valido_q <= bus.Band_Listo;
      if (bus.Band_Listo) begin
        resultado_q <= res_clamped;
        sat_q       <= nxt_sat | clamp_hi | clamp_lo;
        err_q       <= nxt_err;
      end
      // Same-cycle read sees the old entry; the write lands at this edge.
      if (bus.coef_we && ({1'b0, bus.coef_addr} < 4'(NCONST)))
        coef[bus.coef_addr] <= bus.coef_data;
    end
  end

  assign bus.resultado  = resultado_q;
  assign bus.res_valido = res_valido_q;
  assign bus.sat        = sat_q;
  assign bus.err_seq    = err_q;

endmodule
